// File: rtl/capture_seq_ctrl.sv
// ADC capture-and-readout sequencer: fills the capture memory, then replays it as framed packets.
// Optional ramp self-test path is compiled in with `define CAPSEQ_SELF_TEST_EN.
module capture_seq_ctrl #(
   parameter int AW = 15,
   parameter int DW = 18
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_capture_mode,
   input  logic          cfg_capture_start,
   input  logic          cfg_capture_again,
   input  logic [1:0]    cfg_pkt_data_length,
   input  logic [15:0]   cfg_pkt_idle_length,
`ifdef CAPSEQ_SELF_TEST_EN
   input  logic          cfg_self_test_mode,
`endif
   input  logic          rd_en,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_wr_addr,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [DW-1:0] mem_rd_data,
   output logic [DW-1:0] pkt_data,
   output logic          pkt_valid,
   output logic          pkt_sop,
   output logic          pkt_eop,
   output logic          busy,
   output logic          done
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CAPTURE = 3'd1;
   localparam logic [2:0] S_SEND    = 3'd2;
   localparam logic [2:0] S_GAP     = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [AW-1:0] ADDR_LAST = '1;
   localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [2:0]    state_q, state_d;
   logic          start_q, again_q;
   logic          mode_q, mode_d;
   logic [1:0]    len_q, len_d;
   logic [15:0]   idle_q, idle_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [8:0]    word_cnt_q, word_cnt_d;
   logic [15:0]   gap_cnt_q, gap_cnt_d;
   logic          pkt_valid_q, pkt_valid_d;
   logic          pkt_sop_q, pkt_sop_d;
   logic          pkt_eop_q, pkt_eop_d;
   logic          selftest_q;
`ifdef CAPSEQ_SELF_TEST_EN
   logic          selftest_d;
   logic [AW-1:0] pkt_addr_q, pkt_addr_d;
`endif

   logic       start_rise, again_rise, abort, enter_capture, last_word;
   logic [8:0] word_last;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      len_d       = len_q;
      idle_d      = idle_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      word_cnt_d  = word_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      pkt_valid_d = 1'b0;
      pkt_sop_d   = 1'b0;
      pkt_eop_d   = 1'b0;
`ifdef CAPSEQ_SELF_TEST_EN
      selftest_d  = selftest_q;
      pkt_addr_d  = pkt_addr_q;
`endif
      start_rise    = cfg_capture_start & ~start_q;
      again_rise    = cfg_capture_again & ~again_q;
      abort         = (state_q != S_IDLE) & ~cfg_capture_start;
      enter_capture = 1'b0;
      word_last     = 9'((10'd64 << len_q) - 10'd1);
      last_word     = (word_cnt_q == word_last) | (rd_addr_q == ADDR_LAST);

      case (state_q)
         S_IDLE: enter_capture = start_rise;
         S_CAPTURE: begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
            if (wr_addr_q == ADDR_LAST) begin
               state_d    = S_SEND;
               rd_addr_d  = '0;
               word_cnt_d = '0;
            end
         end
         S_SEND: begin
            if (rd_en) begin
               pkt_valid_d = 1'b1;
               pkt_sop_d   = (word_cnt_q == 9'd0);
               pkt_eop_d   = last_word;
               rd_addr_d   = rd_addr_q + ADDR_ONE;
               word_cnt_d  = word_cnt_q + 9'd1;
`ifdef CAPSEQ_SELF_TEST_EN
               pkt_addr_d  = rd_addr_q;
`endif
               if (rd_addr_q == ADDR_LAST) begin
                  state_d = S_DONE;
               end else if (last_word) begin
                  word_cnt_d = '0;
                  gap_cnt_d  = '0;
                  if (idle_q != 16'd0) state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (rd_en) begin
               gap_cnt_d = gap_cnt_q + 16'd1;
               if (gap_cnt_q == idle_q - 16'd1) begin
                  state_d    = S_SEND;
                  word_cnt_d = '0;
                  gap_cnt_d  = '0;
               end
            end
         end
         S_DONE: enter_capture = mode_q | again_rise;
         default: state_d = S_IDLE;
      endcase

      if (enter_capture) begin
         state_d   = S_CAPTURE;
         wr_addr_d = '0;
         mode_d    = cfg_capture_mode;
         len_d     = cfg_pkt_data_length;
         idle_d    = cfg_pkt_idle_length;
`ifdef CAPSEQ_SELF_TEST_EN
         selftest_d = cfg_self_test_mode;
`endif
      end

      // Abort wins over every other transition and also kills the in-flight read's valid.
      if (abort) begin
         state_d     = S_IDLE;
         wr_addr_d   = '0;
         rd_addr_d   = '0;
         word_cnt_d  = '0;
         gap_cnt_d   = '0;
         pkt_valid_d = 1'b0;
         pkt_sop_d   = 1'b0;
         pkt_eop_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         start_q     <= 1'b0;
         again_q     <= 1'b0;
         mode_q      <= 1'b0;
         len_q       <= '0;
         idle_q      <= '0;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         word_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         pkt_valid_q <= 1'b0;
         pkt_sop_q   <= 1'b0;
         pkt_eop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= cfg_capture_start;
         again_q     <= cfg_capture_again;
         mode_q      <= mode_d;
         len_q       <= len_d;
         idle_q      <= idle_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         word_cnt_q  <= word_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         pkt_valid_q <= pkt_valid_d;
         pkt_sop_q   <= pkt_sop_d;
         pkt_eop_q   <= pkt_eop_d;
      end
   end

`ifdef CAPSEQ_SELF_TEST_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         selftest_q <= 1'b0;
         pkt_addr_q <= '0;
      end else begin
         selftest_q <= selftest_d;
         pkt_addr_q <= pkt_addr_d;
      end
   end
`else
   assign selftest_q = 1'b0;
`endif

   always_comb begin
      mem_wr_en   = (state_q == S_CAPTURE) & ~selftest_q;
      mem_wr_addr = (state_q == S_CAPTURE) ? wr_addr_q : '0;
      mem_rd_en   = (state_q == S_SEND) & rd_en;
      mem_rd_addr = mem_rd_en ? rd_addr_q : '0;
      pkt_valid   = pkt_valid_q;
      pkt_sop     = pkt_sop_q;
      pkt_eop     = pkt_eop_q;
      pkt_data    = '0;
`ifdef CAPSEQ_SELF_TEST_EN
      if (pkt_valid_q) pkt_data = selftest_q ? DW'(pkt_addr_q) : mem_rd_data;
`else
      if (pkt_valid_q) pkt_data = mem_rd_data;
`endif
      busy        = (state_q == S_CAPTURE) | (state_q == S_SEND) | (state_q == S_GAP);
      done        = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Bench for capture_seq_ctrl (AW=8): logs every memory/packet event with its cycle and
// compares each run against the address/slot arithmetic of the packet framing rules.
module tb_capture_seq_ctrl;

   localparam int AW = 8;
   localparam int DW = 18;
   localparam int D  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_capture_mode, cfg_capture_start, cfg_capture_again;
   logic [1:0]    cfg_pkt_data_length;
   logic [15:0]   cfg_pkt_idle_length;
   logic          rd_en;
   logic          mem_wr_en, mem_rd_en;
   logic [AW-1:0] mem_wr_addr, mem_rd_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic [DW-1:0] pkt_data;
   logic          pkt_valid, pkt_sop, pkt_eop, busy, done;

   capture_seq_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .cfg_capture_mode(cfg_capture_mode), .cfg_capture_start(cfg_capture_start),
      .cfg_capture_again(cfg_capture_again), .cfg_pkt_data_length(cfg_pkt_data_length),
      .cfg_pkt_idle_length(cfg_pkt_idle_length), .rd_en(rd_en),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          addr;
      logic [31:0] data;
      logic        sop;
      logic        eop;
   } ev_t;

   ev_t         wq[$], rq[$], pq[$];
   int          enq[$], dq[$];
   logic [DW-1:0] tbmem [0:D-1];
   int          cyc = 0;
   int          ntests = 0, nfail = 0;
   int          rd_period = 4;
   logic        done_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= tbmem[mem_rd_addr];

   // ADC samples are random; each write is logged so packet data can be predicted per address.
   always @(negedge clk) begin
      ev_t e;
      logic [DW-1:0] v;
      if (!rst) begin
         e.sop = 1'b0; e.eop = 1'b0;
         if (mem_wr_en) begin
            v = DW'($urandom);
            tbmem[mem_wr_addr] = v;
            e.cyc = cyc; e.addr = int'(mem_wr_addr); e.data = 32'(v);
            wq.push_back(e);
         end
         if (mem_rd_en) begin
            e.cyc = cyc; e.addr = int'(mem_rd_addr); e.data = '0;
            rq.push_back(e);
         end
         if (pkt_valid) begin
            e.cyc = cyc; e.addr = 0; e.data = 32'(pkt_data); e.sop = pkt_sop; e.eop = pkt_eop;
            pq.push_back(e);
         end
         if (rd_en) enq.push_back(cyc);
         if (done && !done_prev) dq.push_back(cyc);
         done_prev = done;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rd_period != 0) rd_en = ((cyc % rd_period) == 0);
      else rd_en = !rd_en && ($urandom_range(0, 2) == 0);
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (done !== 1'b1 && n < bound) begin tick(); n++; end
      chk("done_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic wait_pkts(input int cnt, input int bound);
      int n = 0;
      while (pq.size() < cnt && n < bound) begin tick(); n++; end
      chk("pkt_timeout", {31'd0, pq.size() >= cnt}, 32'd1);
   endtask

   task automatic clear_logs();
      wq.delete(); rq.delete(); pq.delete(); enq.delete(); dq.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_wr_en"},   {31'd0, mem_wr_en}, 32'd0);
      chk({tag, "_wr_addr"}, 32'(mem_wr_addr), 32'd0);
      chk({tag, "_rd_en"},   {31'd0, mem_rd_en}, 32'd0);
      chk({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
      chk({tag, "_valid"},   {31'd0, pkt_valid}, 32'd0);
      chk({tag, "_sop"},     {31'd0, pkt_sop}, 32'd0);
      chk({tag, "_eop"},     {31'd0, pkt_eop}, 32'd0);
      chk({tag, "_data"},    32'(pkt_data), 32'd0);
      chk({tag, "_busy"},    {31'd0, busy}, 32'd0);
      chk({tag, "_done"},    {31'd0, done}, 32'd0);
   endtask

   // Writes: addr j at cycle k0+1+j. Word j is read on rd_en slot j + idle*(j/L) after CAPTURE.
   task automatic check_run(input int k0, input int len, input int idle, output int last);
      int          plen, s, rc, consumed;
      logic [31:0] vals [0:D-1];
      ev_t         w, r, p;
      plen = 64 << len;
      rc   = -1;
      for (int j = 0; j < D; j++) begin
         if (wq.size() == 0) begin chk("wr_missing", 32'(j), 32'(D)); break; end
         w = wq.pop_front();
         chk("wr_cyc", 32'(w.cyc), 32'(k0 + 1 + j));
         chk("wr_addr", 32'(w.addr), 32'(j));
         vals[j] = w.data;
      end
      while (enq.size() > 0 && enq[0] < k0 + D + 1) void'(enq.pop_front());
      for (int j = 0; j < D; j++) begin
         s = j + idle * (j / plen);
         if (s >= enq.size() || rq.size() == 0 || pq.size() == 0) begin
            chk("rd_missing", 32'(j), 32'(D));
            break;
         end
         rc = enq[s];
         r  = rq.pop_front();
         chk("rd_cyc", 32'(r.cyc), 32'(rc));
         chk("rd_addr", 32'(r.addr), 32'(j));
         p  = pq.pop_front();
         chk("pkt_cyc", 32'(p.cyc), 32'(rc + 1));
         chk("pkt_data", p.data, vals[j]);
         chk("pkt_sop", {31'd0, p.sop}, {31'd0, (j % plen) == 0});
         chk("pkt_eop", {31'd0, p.eop}, {31'd0, ((j % plen) == plen - 1) || (j == D - 1)});
      end
      consumed = (D - 1) + idle * ((D - 1) / plen) + 1;
      for (int i = 0; i < consumed && enq.size() > 0; i++) void'(enq.pop_front());
      last = rc;
      if (dq.size() == 0) chk("done_missing", 32'd0, 32'd1);
      else chk("done_cyc", 32'(dq.pop_front()), 32'(rc + 1));
   endtask

   initial begin
      int k0, last1, last2, idl, ln;
      ev_t w;
      rst = 1'b1;
      cfg_capture_mode = 1'b0; cfg_capture_start = 1'b0; cfg_capture_again = 1'b0;
      cfg_pkt_data_length = 2'd0; cfg_pkt_idle_length = 16'd0; rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      tick(); tick();
      check_outputs_zero("post_reset");

      // Single-shot, back-to-back packets; an again pulse mid-SEND must change nothing.
      clear_logs();
      cfg_capture_start = 1'b1; k0 = cyc;
      wait_pkts(40, 3000);
      cfg_capture_again = 1'b1; tick(); tick(); tick(); cfg_capture_again = 1'b0;
      wait_done(3000);
      tick(); tick(); tick();
      chk("single_done_hold", {31'd0, done}, 32'd1);
      chk("single_done_busy", {31'd0, busy}, 32'd0);
      check_run(k0, 0, 0, last1);
      chk("run1_extra_rd", 32'(rq.size()), 32'd0);
      chk("run1_extra_pkt", 32'(pq.size()), 32'd0);

      // Again from DONE re-shadows config: single truncated 512-word packet.
      cfg_pkt_data_length = 2'd3;
      idl = $urandom_range(1, 9);
      cfg_pkt_idle_length = 16'(idl);
      cfg_capture_again = 1'b1; k0 = cyc;
      tick(); cfg_capture_again = 1'b0;
      wait_done(3000);
      tick();
      check_run(k0, 3, idl, last1);
      chk("run2_extra_pkt", 32'(pq.size()), 32'd0);

      // Idle gaps of 5 slots with irregular rd_en spacing.
      cfg_capture_start = 1'b0; tick(); tick();
      chk("abort_done_busy", {31'd0, busy}, 32'd0);
      chk("abort_done_done", {31'd0, done}, 32'd0);
      clear_logs();
      cfg_pkt_data_length = 2'd0; cfg_pkt_idle_length = 16'd5; rd_period = 0;
      cfg_capture_start = 1'b1; k0 = cyc;
      tick();
      wait_done(6000);
      tick();
      check_run(k0, 0, 5, last1);
      chk("gap_extra_rd", 32'(rq.size()), 32'd0);

      // Continuous mode; a length change mid-SEND applies only to the following run.
      cfg_capture_start = 1'b0; tick(); tick();
      clear_logs();
      cfg_capture_mode = 1'b1; cfg_pkt_data_length = 2'd0; rd_period = 3;
      idl = $urandom_range(0, 3);
      cfg_pkt_idle_length = 16'(idl);
      cfg_capture_start = 1'b1; k0 = cyc;
      wait_pkts(20, 3000);
      cfg_pkt_data_length = 2'd1;
      wait_done(3000);
      tick();
      chk("cont_done_1clk", {31'd0, done}, 32'd0);
      wait_done(3000);
      repeat (5) tick();
      cfg_capture_start = 1'b0; cfg_capture_mode = 1'b0;
      tick(); tick();
      check_run(k0, 0, idl, last1);
      check_run(last1 + 1, 1, idl, last2);
      if (wq.size() == 0) chk("run3_wr_missing", 32'd0, 32'd1);
      else begin
         w = wq.pop_front();
         chk("run3_wr_cyc", 32'(w.cyc), 32'(last2 + 2));
         chk("run3_wr_addr", 32'(w.addr), 32'd0);
      end

      // Abort with a read in flight, then restart from write address 0.
      clear_logs();
      cfg_pkt_data_length = 2'd0; cfg_pkt_idle_length = 16'd0; rd_period = 4;
      cfg_capture_start = 1'b1;
      wait_pkts(10, 3000);
      tick();
      rd_en = 1'b1; cfg_capture_start = 1'b0;
      #2;
      chk("abort_rd_inflight", {31'd0, mem_rd_en}, 32'd1);
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      check_outputs_zero("abort");
      repeat (4) tick();
      chk("abort_stay_idle", {31'd0, busy}, 32'd0);
      chk("abort_no_pkt", {31'd0, pkt_valid}, 32'd0);
      clear_logs();
      ln  = $urandom_range(0, 3);
      idl = $urandom_range(0, 4);
      cfg_pkt_data_length = 2'(ln); cfg_pkt_idle_length = 16'(idl); rd_period = 0;
      cfg_capture_start = 1'b1; k0 = cyc;
      tick();
      wait_done(8000);
      tick();
      check_run(k0, ln, idl, last1);
      chk("restart_extra_pkt", 32'(pq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/capture_seq_ctrl.md
Name: capture_seq_ctrl

Overview:
- Sequences one ADC capture-and-readout cycle for the packet controller.
- Capture phase: fills the capture memory with a free-running write address.
- Readout phase: reads the memory back at the CLK_RD strobe rate and emits framed packets with programmable idle gaps on the 18-bit pad data bus.
- Sits between the register-file controls (capture start/again/mode, packet/idle length) and the capture memory plus pad output path.

Parameters:
- AW, 15, memory address width; DEPTH = 2**AW words.
- DW, 18, data word width (pad bus width).

Ports:
- clk  in  1  system clock (200 MHz domain).
- rst  in  1  asynchronous reset, active-high.
- cfg_capture_mode  in  1  0 = single-shot, 1 = continuous re-capture.
- cfg_capture_start  in  1  level; a rising edge arms a run, low aborts.
- cfg_capture_again  in  1  rising edge re-runs from DONE.
- cfg_pkt_data_length  in  2  packet words = 64 << value (64/128/256/512).
- cfg_pkt_idle_length  in  16  idle strobe slots between packets.
- rd_en  in  1  read strobe (DATA_RD_EN), one clk wide.
- mem_wr_en  out  1  capture write enable.
- mem_wr_addr  out  AW  capture write address.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  AW  memory read address.
- mem_rd_data  in  DW  read data, valid 1 clk after mem_rd_en.
- pkt_data  out  DW  packet word to the pad path.
- pkt_valid  out  1  pkt_data valid.
- pkt_sop  out  1  first word of a packet.
- pkt_eop  out  1  last word of a packet.
- busy  out  1  state is CAPTURE, SEND or GAP.
- done  out  1  state is DONE.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; the start/again edge-detect registers cleared.
- Start/again edges are detected on registered copies of the inputs.
- States:
  - IDLE: on start rise -> CAPTURE. On entry to CAPTURE, cfg_capture_mode, cfg_pkt_data_length and cfg_pkt_idle_length are shadowed; later changes are ignored until the next CAPTURE entry.
  - CAPTURE: mem_wr_en = 1 every clk; mem_wr_addr runs 0 .. DEPTH-1, so CAPTURE lasts exactly DEPTH clks. After the write at DEPTH-1 -> SEND with rd_addr = 0 and word count = 0.
  - SEND: acts only on rd_en cycles. On each rd_en: mem_rd_en = 1 with mem_rd_addr = rd_addr, then rd_addr and word count increment.
    - Exactly 1 clk later: pkt_valid = 1 and pkt_data = mem_rd_data.
    - pkt_sop is set on word 0; pkt_eop on word PKT_LEN-1, or on read address DEPTH-1 (truncated last packet).
    - After the read at DEPTH-1 -> DONE.
    - Otherwise, after the eop read -> GAP, or stay in SEND with word count reset if the idle length is 0.
  - GAP: counts rd_en cycles; after idle_length of them -> SEND with word count = 0. No reads are issued during GAP.
  - DONE: done = 1.
    - Continuous mode: -> CAPTURE on the next clk.
    - Single-shot mode: a capture_again rise -> CAPTURE (re-shadows config).
- Edge events:
  - start low in any non-IDLE state -> IDLE next clk, all outputs 0. The pkt_valid of an already-issued read is suppressed.
  - start rise while not IDLE is ignored; again rise outside DONE is ignored.
  - Abort takes priority over every other transition in the same clk.
- pkt_valid cadence equals the rd_en cadence with 1 clk latency; no buffering, no backpressure.
- Counters are AW wide and never exceed DEPTH-1; word count is 9 bits.

Optional Feature:
- Macro CAPSEQ_SELF_TEST_EN.
- Defined: adds input cfg_self_test_mode (1 bit, shadowed on CAPTURE entry). When set, mem_wr_en stays 0 during CAPTURE (the CAPTURE timing is unchanged), and pkt_data = the zero-extended read address of that word instead of mem_rd_data (ramp pattern).
- Undefined: the port is absent and pkt_data is always mem_rd_data.

Test Plan:
- AW=8, len=0, idle=0, rd_en every 4 clks, start rise -> 256 write clks (addr 0..255), then 4 packets of 64 words. Packets are back-to-back with sop at words 0/64/128/192 and eop at 63/127/191/255. pkt_valid occurs 1 clk after each rd_en; done=1 afterwards.
- AW=8, len=3 (512 words) -> a single truncated packet: sop at addr 0, eop at addr 255, then DONE.
- AW=8, len=0, idle=5 -> exactly 5 rd_en slots with no mem_rd_en between eop and the next sop; 3 gaps total.
- Single-shot then again rise in DONE -> second full CAPTURE+SEND. An again rise during SEND is ignored, with no change in the sequence.
- Continuous mode -> DONE lasts 1 clk, then CAPTURE restarts at addr 0. Changing len mid-SEND takes effect only in the next run.
- Drop start mid-SEND with a read in flight -> next clk state IDLE, pkt_valid/sop/eop/mem_* all 0, busy=0. A new start rise then restarts at write addr 0.
